// File: rtl/uart_rx_pkg.sv
// Shared types and sizing helpers for the parametrised UART receive engine.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    LOAD      = 3'd5
  } rx_state_t;

  // Bits needed to hold a counter running 0..terminal-1.
  function automatic int cnt_width(input int terminal);
    return (terminal <= 2) ? 1 : $clog2(terminal);
  endfunction

endpackage

// File: rtl/uart_rx_fsm_param_timer.sv
// Mid-bit sampling timer: one-cycle strobe half a bit after clear, then once per bit.
module rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic sample_strobe
);

  localparam int W = cnt_width(CLKS_PER_BIT);
  localparam logic [W-1:0] HALF_LAST = W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [W-1:0] FULL_LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;
  logic         first_half;

  assign sample_strobe = enable && (count == (first_half ? HALF_LAST : FULL_LAST));

  // Counter restarts on every strobe, so each sample sits one full period after the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      first_half <= 1'b1;
    end else if (clear) begin
      count      <= '0;
      first_half <= 1'b1;
    end else if (sample_strobe) begin
      count      <= '0;
      first_half <= 1'b0;
    end else if (enable) begin
      count      <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fsm_param.sv
// Parametrised UART receiver: start validation, mid-bit sampling, stop/parity check, output buffer.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fsm_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int BW = cnt_width(DATA_BITS);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  rx_state_t             state, state_next;
  logic                  prev_serial;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]  shift;
  logic                  stop_bad;
  logic                  commit;
  logic                  frame_good;
  logic                  strobe;
  logic                  start_edge;
  logic                  timer_en;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = 1'(PARITY_ODD);
  logic                  parity_bad;
  assign frame_good = commit && !stop_bad && !parity_bad;
`else
  assign frame_good = commit && !stop_bad;
`endif

  // Only a genuine 1->0 transition starts a frame; a line held low never does.
  assign start_edge = (state == IDLE) && !serial_in && prev_serial;
  assign timer_en   = (state == START_CHK) || (state == DATA) ||
                      (state == PARITY)    || (state == STOP);

  rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk           (clk),
    .rst           (rst),
    .clear         (start_edge),
    .enable        (timer_en),
    .sample_strobe (strobe)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; every sampling decision waits on the timer strobe.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start_edge) state_next = START_CHK;
      START_CHK: if (strobe) state_next = serial_in ? IDLE : DATA;
      DATA: begin
        if (strobe && (bit_cnt == DATA_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
      PARITY:    if (strobe) state_next = STOP;
      STOP:      if (strobe && (bit_cnt == STOP_LAST)) state_next = LOAD;
      LOAD:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Frame datapath: line history, bit counting, shifting and per-frame error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_serial <= 1'b1;
      bit_cnt     <= '0;
      shift       <= '0;
      stop_bad    <= 1'b0;
      commit      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad  <= 1'b0;
`endif
    end else begin
      prev_serial <= serial_in;
      commit      <= (state == LOAD);
      if (start_edge) begin
        bit_cnt    <= '0;
        stop_bad   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad <= 1'b0;
`endif
      end else if (strobe) begin
        case (state)
          DATA: begin
            shift   <= {serial_in, shift[DATA_BITS-1:1]};
            bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + BW'(1);
          end
`ifdef UART_RX_PARITY_EN
          PARITY: parity_bad <= (serial_in != (^shift ^ PAR_ODD));
`endif
          STOP: begin
            if (!serial_in) stop_bad <= 1'b1;
            bit_cnt <= (bit_cnt == STOP_LAST) ? '0 : bit_cnt + BW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Output buffer; results appear the edge after LOAD, and a load beats a same-cycle read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      if (frame_good) begin
        rx_data    <= shift;
        data_ready <= 1'b1;
      end else if (data_read) begin
        data_ready <= 1'b0;
      end
      if (frame_good && data_ready && !data_read) overrun_error <= 1'b1;
      if (commit) begin
        framing_error <= stop_bad;
`ifdef UART_RX_PARITY_EN
        parity_error  <= !stop_bad && parity_bad;
`else
        parity_error  <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm_param.sv
// Directed bench for uart_rx_fsm_param: 8N1 instance plus a 7-bit, 2-stop, odd-parity instance.
module tb_uart_rx_fsm_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_a, serial_b;
  logic       data_read;
  logic       data_read_b;
  logic [7:0] rx_data_a;
  logic [6:0] rx_data_b;
  logic       data_ready_a, overrun_a, framing_a, parity_a, busy_a;
  logic       data_ready_b, overrun_b, framing_b, parity_b, busy_b;

  always #5 clk = ~clk;

  uart_rx_fsm_param #(.DATA_BITS(8), .STOP_BITS(1), .CLKS_PER_BIT(16), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .serial_in(serial_a), .data_read(data_read),
    .rx_data(rx_data_a), .data_ready(data_ready_a), .overrun_error(overrun_a),
    .framing_error(framing_a), .parity_error(parity_a), .busy(busy_a)
  );

  uart_rx_fsm_param #(.DATA_BITS(7), .STOP_BITS(2), .CLKS_PER_BIT(16), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rst(rst), .serial_in(serial_b), .data_read(data_read_b),
    .rx_data(rx_data_b), .data_ready(data_ready_b), .overrun_error(overrun_b),
    .framing_error(framing_b), .parity_error(parity_b), .busy(busy_b)
  );

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       read_before;
    logic [7:0] exp_rx;
    logic       exp_ready;
    logic       exp_ovr;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int rise_cyc = -1;
  int fall_cyc = -1;
  int read_edge = -1;
  int busy_cnt = 0;
  logic dr_prev = 1'b0;
  logic busy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample #1 after the edge, track DUT-A events, schedule data_read.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (data_ready_a && !dr_prev) rise_cyc = cyc;
    if (!busy_a && busy_prev) fall_cyc = cyc;
    dr_prev   = data_ready_a;
    busy_prev = busy_a;
    busy_cnt += int'(busy_a);
    data_read = (cyc + 1 == read_edge);
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) serial_a = v;
    else          serial_b = v;
  endtask

  task automatic pulse_read();
    data_read = 1'b1;
    tick();
  endtask

  // 16 clocks per symbol; read_off > 0 pulses data_read so it is sampled at edge t0+read_off.
  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                            input bit par_on, input logic par_bit,
                            input logic [1:0] stops, input int nstops, input int read_off);
    set_line(sel, 1'b0);
    t0 = cyc + 1;
    rise_cyc = -1;
    fall_cyc = -1;
    if (read_off > 0) read_edge = t0 + read_off;
    repeat (16) tick();
    for (int i = 0; i < nbits; i++) begin
      set_line(sel, data[i]);
      repeat (16) tick();
    end
    if (par_on) begin
      set_line(sel, par_bit);
      repeat (16) tick();
    end
    for (int i = 0; i < nstops; i++) begin
      set_line(sel, stops[i]);
      repeat (16) tick();
    end
    set_line(sel, 1'b1);
    tick();
    read_edge = -1;
  endtask

  initial begin
    vecs[0] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h02, 1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; serial_a = 1'b1; serial_b = 1'b1; data_read = 1'b0; data_read_b = 1'b0;
    repeat (3) tick();
    check("reset_rx", {24'd0, rx_data_a}, 32'h0);
    check("reset_flags", {27'd0, data_ready_a, overrun_a, framing_a, parity_a, busy_a}, 32'h0);
    rst = 1'b0;
    repeat (4) tick();

    // Short low glitch on an idle line must be rejected.
    busy_cnt = 0;
    set_line(0, 1'b0);
    repeat (4) tick();
    set_line(0, 1'b1);
    repeat (20) tick();
    check("glitch_busy_seen", {31'd0, (busy_cnt > 0)}, 32'h1);
    check("glitch_busy_max9", {31'd0, (busy_cnt <= 9)}, 32'h1);
    check("glitch_ready", {31'd0, data_ready_a}, 32'h0);
    check("glitch_fe", {31'd0, framing_a}, 32'h0);

    // 0xA5 with exact latency.
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 2'b11, 1, 0);
    check("a5_rx", {24'd0, rx_data_a}, 32'hA5);
    check("a5_latency", rise_cyc - t0, 32'd154);
    check("a5_busy_fall", fall_cyc - t0, 32'd153);
    check("a5_fe", {31'd0, framing_a}, 32'h0);
    check("a5_busy_idle", {31'd0, busy_a}, 32'h0);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].read_before) pulse_read();
      send_frame(0, {1'b0, vecs[v].data}, 8, 1'b0, 1'b0, {1'b1, vecs[v].stop}, 1, 0);
      check($sformatf("vec%0d_rx", v), {24'd0, rx_data_a}, {24'd0, vecs[v].exp_rx});
      check($sformatf("vec%0d_ready", v), {31'd0, data_ready_a}, {31'd0, vecs[v].exp_ready});
      check($sformatf("vec%0d_ovr", v), {31'd0, overrun_a}, {31'd0, vecs[v].exp_ovr});
      check($sformatf("vec%0d_fe", v), {31'd0, framing_a}, {31'd0, vecs[v].exp_fe});
    end

    // Reset mid-frame at t0+60.
    set_line(0, 1'b0);
    t0 = cyc + 1;
    while (cyc < t0 + 59) tick();
    rst = 1'b1;
    set_line(0, 1'b1);
    tick();
    check("midrst_rx", {24'd0, rx_data_a}, 32'h0);
    check("midrst_flags", {27'd0, data_ready_a, overrun_a, framing_a, parity_a, busy_a}, 32'h0);
    rst = 1'b0;
    repeat (5) tick();
    send_frame(0, 9'h07E, 8, 1'b0, 1'b0, 2'b11, 1, 0);
    check("7e_rx", {24'd0, rx_data_a}, 32'h7E);
    check("7e_ready_ovr_fe", {29'd0, data_ready_a, overrun_a, framing_a}, 32'b100);

    // Read in the first visible cycle, then a load racing a read.
    pulse_read();
    send_frame(0, 9'h001, 8, 1'b0, 1'b0, 2'b11, 1, 155);
    check("r01_ready", {31'd0, data_ready_a}, 32'h0);
    check("r01_rx", {24'd0, rx_data_a}, 32'h01);
    send_frame(0, 9'h002, 8, 1'b0, 1'b0, 2'b11, 1, 0);
    check("r02_ready_ovr", {30'd0, data_ready_a, overrun_a}, 32'b10);
    send_frame(0, 9'h003, 8, 1'b0, 1'b0, 2'b11, 1, 154);
    check("r03_rx", {24'd0, rx_data_a}, 32'h03);
    check("r03_ready_ovr", {30'd0, data_ready_a, overrun_a}, 32'b10);

    // 7 data bits, 2 stops, odd parity when compiled in.
    repeat (3) tick();
    send_frame(1, 9'h055, 7, PAR_ON, 1'b1, 2'b11, 2, 0);
    check("b55_rx", {25'd0, rx_data_b}, 32'h55);
    check("b55_ready_fe_pe", {29'd0, data_ready_b, framing_b, parity_b}, 32'b100);
    send_frame(1, 9'h02A, 7, PAR_ON, 1'b0, 2'b01, 2, 0);
    check("b2a_badstop_rx", {25'd0, rx_data_b}, 32'h55);
    check("b2a_badstop_fe", {31'd0, framing_b}, 32'h1);
    if (PAR_ON) begin
      send_frame(1, 9'h02A, 7, 1'b1, 1'b1, 2'b11, 2, 0);
      check("b2a_badpar_rx", {25'd0, rx_data_b}, 32'h55);
      check("b2a_badpar_flags", {29'd0, data_ready_b, framing_b, parity_b}, 32'b101);
    end
    send_frame(1, 9'h02A, 7, PAR_ON, 1'b0, 2'b11, 2, 0);
    check("b2a_rx", {25'd0, rx_data_b}, 32'h2A);
    check("b2a_flags", {29'd0, data_ready_b, framing_b, parity_b}, 32'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
